// File: rtl/adc_sample_player_if.sv
// Bus bundle for adc_sample_player: buffer write port, playback control and sample stream.
// The adc_or member exists only when ADC_PLAYER_OVR_EN is defined.
interface adc_sample_player_if #(
  parameter int DATA_W = 10,
  parameter int ADDR_W = 10,
  parameter int CH_N   = 1,
  parameter int DIV_W  = 8
) ();
  logic                   wr_en;
  logic [1:0]             wr_ch;
  logic [ADDR_W-1:0]      wr_addr;
  logic [DATA_W-1:0]      wr_data;
  logic                   start;
  logic                   stop;
  logic                   loop;
  logic [ADDR_W-1:0]      play_len;
  logic [DIV_W-1:0]       rate_div;
  logic [CH_N*DATA_W-1:0] sample_out;
  logic                   sample_valid;
  logic                   busy;
  logic                   done;
`ifdef ADC_PLAYER_OVR_EN
  logic                   adc_or;
`endif

  modport master (
    output wr_en, wr_ch, wr_addr, wr_data, start, stop, loop, play_len, rate_div,
`ifdef ADC_PLAYER_OVR_EN
    input  adc_or,
`endif
    input  sample_out, sample_valid, busy, done
  );

  modport slave (
    input  wr_en, wr_ch, wr_addr, wr_data, start, stop, loop, play_len, rate_div,
`ifdef ADC_PLAYER_OVR_EN
    output adc_or,
`endif
    output sample_out, sample_valid, busy, done
  );
endinterface

// File: rtl/adc_sample_player.sv
// On-chip ADC sample source: per-channel RAM banks replayed one-shot or looped at a divided rate.
// Defining ADC_PLAYER_OVR_EN adds the registered full-scale flag adc_or.
module adc_sample_player #(
  parameter int DATA_W = 10,
  parameter int ADDR_W = 10,
  parameter int CH_N   = 1,
  parameter int DIV_W  = 8
) (
  input logic                adc_clk,
  input logic                rst,
  adc_sample_player_if.slave bus
);
  localparam int              DEPTH    = 1 << ADDR_W;
  localparam int              SMP_W    = CH_N * DATA_W;
  localparam logic [ADDR_W:0] FULL_LEN = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_PLAY  = 2'd2
  } state_t;

  state_t            state_r, state_s;
  logic [ADDR_W-1:0] rd_addr_r, rd_addr_s;
  logic [DIV_W-1:0]  cnt_r, cnt_s;
  logic [DIV_W-1:0]  div_r;
  logic [ADDR_W:0]   len_r;
  logic              loop_r;
  logic              accept_s, rd_en_s, emit_s, fin_s, tc_s, last_s;
  logic [SMP_W-1:0]  rd_data_s;
  logic [SMP_W-1:0]  sample_out_r;
  logic              sample_valid_r, busy_r, done_r;

  // One bank per channel; a read only happens when a new address is fetched, so the
  // held read data is immune to later writes, and a same-cycle write returns old data.
  for (genvar k = 0; k < CH_N; k++) begin : g_bank
    logic [DATA_W-1:0] ram_r [0:DEPTH-1];
    logic [DATA_W-1:0] rd_q_r;

    // Bank write port
    always_ff @(posedge adc_clk) begin
      if (bus.wr_en && (bus.wr_ch == 2'(k))) ram_r[bus.wr_addr] <= bus.wr_data;
      else ram_r[bus.wr_addr] <= ram_r[bus.wr_addr];
    end

    // Bank synchronous read port
    always_ff @(posedge adc_clk) begin
      if (rd_en_s) rd_q_r <= ram_r[rd_addr_s];
      else rd_q_r <= rd_q_r;
    end

    assign rd_data_s[k*DATA_W +: DATA_W] = rd_q_r;
  end

  // Next-state, read-address and divider logic
  always_comb begin
    state_s   = state_r;
    rd_addr_s = rd_addr_r;
    cnt_s     = cnt_r;
    accept_s  = 1'b0;
    rd_en_s   = 1'b0;
    emit_s    = 1'b0;
    fin_s     = 1'b0;
    tc_s      = (cnt_r == div_r);
    last_s    = ({1'b0, rd_addr_r} == (len_r - 1'b1));
    case (state_r)
      ST_IDLE: begin
        // busy_r still high means the previous run ended last cycle
        if (bus.start && !bus.stop && !busy_r) begin
          accept_s  = 1'b1;
          state_s   = ST_PRIME;
          rd_addr_s = {ADDR_W{1'b0}};
          cnt_s     = {DIV_W{1'b0}};
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_PRIME: begin
        if (bus.stop) begin
          state_s = ST_IDLE;
        end else begin
          rd_en_s = 1'b1;
          cnt_s   = {DIV_W{1'b0}};
          state_s = ST_PLAY;
        end
      end
      ST_PLAY: begin
        if (bus.stop) begin
          state_s = ST_IDLE;
        end else if (tc_s) begin
          emit_s = 1'b1;
          cnt_s  = {DIV_W{1'b0}};
          if (!last_s) begin
            rd_addr_s = rd_addr_r + 1'b1;
            rd_en_s   = 1'b1;
          end else if (loop_r) begin
            rd_addr_s = {ADDR_W{1'b0}};
            rd_en_s   = 1'b1;
          end else begin
            fin_s   = 1'b1;
            state_s = ST_IDLE;
          end
        end else begin
          cnt_s = cnt_r + 1'b1;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State register, counters and run parameters captured at an accepted start
  always_ff @(posedge adc_clk) begin
    if (!rst) begin
      state_r   <= ST_IDLE;
      rd_addr_r <= {ADDR_W{1'b0}};
      cnt_r     <= {DIV_W{1'b0}};
      div_r     <= {DIV_W{1'b0}};
      len_r     <= {(ADDR_W+1){1'b0}};
      loop_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      rd_addr_r <= rd_addr_s;
      cnt_r     <= cnt_s;
      if (accept_s) begin
        loop_r <= bus.loop;
        div_r  <= bus.rate_div;
        len_r  <= (bus.play_len == {ADDR_W{1'b0}}) ? FULL_LEN : {1'b0, bus.play_len};
      end else begin
        loop_r <= loop_r;
        div_r  <= div_r;
        len_r  <= len_r;
      end
    end
  end

  // Registered outputs; busy trails the state so it stays high in the done cycle
  always_ff @(posedge adc_clk) begin
    if (!rst) begin
      sample_out_r   <= {SMP_W{1'b0}};
      sample_valid_r <= 1'b0;
      done_r         <= 1'b0;
      busy_r         <= 1'b0;
    end else begin
      sample_valid_r <= emit_s;
      done_r         <= fin_s;
      busy_r         <= (state_r != ST_IDLE);
      if (emit_s) sample_out_r <= rd_data_s;
      else sample_out_r <= sample_out_r;
    end
  end

  assign bus.sample_out   = sample_out_r;
  assign bus.sample_valid = sample_valid_r;
  assign bus.busy         = busy_r;
  assign bus.done         = done_r;

`ifdef ADC_PLAYER_OVR_EN
  logic adc_or_r;

  function automatic logic full_scale(input logic [SMP_W-1:0] smp);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < CH_N; k++) begin
      if ((smp[k*DATA_W +: DATA_W] == {DATA_W{1'b1}}) ||
          (smp[k*DATA_W +: DATA_W] == {DATA_W{1'b0}})) hit = 1'b1;
      else hit = hit;
    end
    return hit;
  endfunction

  // Full-scale flag, updated together with sample_out
  always_ff @(posedge adc_clk) begin
    if (!rst) adc_or_r <= 1'b0;
    else if (emit_s) adc_or_r <= full_scale(rd_data_s);
    else adc_or_r <= adc_or_r;
  end

  assign bus.adc_or = adc_or_r;
`endif
endmodule

// File: tb/tb_adc_sample_player.sv
// Self-checking bench for adc_sample_player: directed scenarios plus randomized runs
// checked against a cycle-index model of the playback schedule.
module tb_adc_sample_player;
  localparam int DATA_W = 10;
  localparam int ADDR_W = 4;
  localparam int CH_N   = 2;
  localparam int DIV_W  = 8;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int SMP_W  = CH_N * DATA_W;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  logic [DATA_W-1:0] mem_m [CH_N][DEPTH];
  logic [SMP_W-1:0]  exp_out;
  logic              exp_or;

  adc_sample_player_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CH_N(CH_N), .DIV_W(DIV_W)) bus_if ();

  adc_sample_player #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CH_N(CH_N), .DIV_W(DIV_W)) dut (
    .adc_clk(clk),
    .rst    (rst),
    .bus    (bus_if)
  );

  always #5 clk = ~clk;

  function automatic logic fs_model(input logic [SMP_W-1:0] s);
    int v;
    for (int ch = 0; ch < CH_N; ch++) begin
      v = int'(s[ch*DATA_W +: DATA_W]);
      if (v == 0 || v == (1 << DATA_W) - 1) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_cycle(input string tag, input logic ev, input logic ed, input logic eb);
    chk({tag, ".valid"}, 64'(bus_if.sample_valid), 64'(ev));
    chk({tag, ".done"}, 64'(bus_if.done), 64'(ed));
    chk({tag, ".busy"}, 64'(bus_if.busy), 64'(eb));
    chk({tag, ".sample"}, 64'(bus_if.sample_out), 64'(exp_out));
`ifdef ADC_PLAYER_OVR_EN
    chk({tag, ".adc_or"}, 64'(bus_if.adc_or), 64'(exp_or));
`endif
  endtask

  // Called at a negedge; the word is written at the following posedge.
  task automatic write_word(input int ch, input int addr, input logic [DATA_W-1:0] d);
    bus_if.wr_en   = 1'b1;
    bus_if.wr_ch   = 2'(ch);
    bus_if.wr_addr = ADDR_W'(addr);
    bus_if.wr_data = d;
    @(negedge clk);
    bus_if.wr_en = 1'b0;
    if (ch < CH_N) mem_m[ch][addr] = d;
  endtask

  // Start at the next posedge (edge 0) and check every cycle. Sample k is due on edge
  // 2+div+k*(div+1); stop_at (0 = none) names the edge where stop is sampled.
  task automatic run_play(input string tag, input int len, input int div, input bit lp,
                          input int stop_at, input bit conflict, input logic [DATA_W-1:0] cval);
    logic [DATA_W-1:0] snap [CH_N][DEPTH];
    int n, first, cl, s, bend;
    bit ev;
    int k;
    snap  = mem_m;
    n     = (len == 0) ? DEPTH : len;
    first = 2 + div;
    cl    = first + (n - 1) * (div + 1);
    s     = (stop_at > 0) ? stop_at : 1000000;
    bend  = lp ? s : ((s < cl) ? s : cl);
    bus_if.play_len = ADDR_W'(len);
    bus_if.rate_div = DIV_W'(div);
    bus_if.loop     = lp;
    bus_if.start    = 1'b1;
    bus_if.stop     = 1'b0;
    @(negedge clk);
    for (int c = 0; c <= bend + 2; c++) begin
      ev = 1'b0;
      k  = 0;
      if (c >= first && c < s && ((c - first) % (div + 1)) == 0) begin
        k = (c - first) / (div + 1);
        if (lp || k < n) ev = 1'b1;
      end
      if (ev) begin
        for (int ch = 0; ch < CH_N; ch++) exp_out[ch*DATA_W +: DATA_W] = snap[ch][k % n];
        exp_or = fs_model(exp_out);
      end
      check_cycle(tag, ev, ev && !lp && (k == n - 1), (c >= 1) && (c <= bend));
      // run parameters and start are scrambled while busy; none of it may take effect
      bus_if.start    = (c + 1 <= bend + 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      bus_if.stop     = (c + 1 == s);
      bus_if.loop     = 1'($urandom_range(0, 1));
      bus_if.play_len = ADDR_W'($urandom_range(0, DEPTH - 1));
      bus_if.rate_div = DIV_W'($urandom_range(0, 7));
      if (conflict && c == 0) begin
        bus_if.wr_en   = 1'b1;
        bus_if.wr_ch   = 2'd0;
        bus_if.wr_addr = {ADDR_W{1'b0}};
        bus_if.wr_data = cval;
      end else begin
        bus_if.wr_en = 1'b0;
      end
      @(negedge clk);
    end
    bus_if.start = 1'b0;
    bus_if.stop  = 1'b0;
    if (conflict) mem_m[0][0] = cval;
  endtask

  initial begin
    int len_v, div_v, s_v;
    bit lp_v;

    rst            = 1'b0;
    bus_if.wr_en   = 1'b0;
    bus_if.wr_ch   = 2'd0;
    bus_if.wr_addr = {ADDR_W{1'b0}};
    bus_if.wr_data = {DATA_W{1'b0}};
    bus_if.start   = 1'b0;
    bus_if.stop    = 1'b0;
    bus_if.loop    = 1'b0;
    bus_if.play_len = {ADDR_W{1'b0}};
    bus_if.rate_div = {DIV_W{1'b0}};
    exp_out        = {SMP_W{1'b0}};
    exp_or         = 1'b0;
    for (int ch = 0; ch < CH_N; ch++)
      for (int a = 0; a < DEPTH; a++) mem_m[ch][a] = {DATA_W{1'b0}};

    // reset held for 4 edges with random control inputs
    for (int i = 0; i < 4; i++) begin
      bus_if.start    = 1'($urandom_range(0, 1));
      bus_if.stop     = 1'($urandom_range(0, 1));
      bus_if.loop     = 1'($urandom_range(0, 1));
      bus_if.play_len = ADDR_W'($urandom);
      bus_if.rate_div = DIV_W'($urandom);
      @(negedge clk);
      check_cycle("reset", 1'b0, 1'b0, 1'b0);
    end
    bus_if.start = 1'b0;
    bus_if.stop  = 1'b0;
    rst = 1'b1;
    @(negedge clk);

    // known contents everywhere, including ignored writes to banks 2 and 3
    for (int a = 0; a < DEPTH; a++) begin
      write_word(0, a, DATA_W'(a));
      write_word(1, a, DATA_W'($urandom_range(1, 1000)));
    end
    write_word(2, 3, 10'h1AB);
    write_word(3, 5, 10'h0CD);

    // one-shot ramp, full depth (play_len 0), one sample per clock
    run_play("oneshot", 0, 0, 1'b0, 0, 1'b0, 10'h000);

    // loop with divider, stopped mid-stream
    write_word(0, 0, 10'd5);
    write_word(0, 1, 10'd6);
    write_word(0, 2, 10'd7);
    write_word(0, 3, 10'd8);
    run_play("loop", 4, 3, 1'b1, 2 + 3 + 9 * 4 + 2, 1'b0, 10'h000);

    // multichannel full-scale sample
    write_word(0, 0, 10'h3FF);
    write_word(1, 0, 10'h000);
    run_play("multi", 1, 0, 1'b0, 0, 1'b0, 10'h000);
    chk("multi.word", 64'(bus_if.sample_out), 64'h003FF);
`ifdef ADC_PLAYER_OVR_EN
    chk("multi.or", 64'(bus_if.adc_or), 64'h1);
`endif

    // start and stop together in IDLE: nothing happens
    bus_if.start = 1'b1;
    bus_if.stop  = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
    bus_if.stop  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_cycle("startstop", 1'b0, 1'b0, 1'b0);
      @(negedge clk);
    end

    // write to address 0 on the cycle it is read: old value emitted, new one on the next run
    write_word(0, 0, 10'h155);
    run_play("conflict", 3, 1, 1'b0, 0, 1'b1, 10'h2AA);
    run_play("conflict2", 1, 0, 1'b0, 0, 1'b0, 10'h000);

    // randomized runs
    for (int it = 0; it < 8; it++) begin
      for (int w = 0; w < 4; w++)
        write_word($urandom_range(0, 3), $urandom_range(0, DEPTH - 1), DATA_W'($urandom));
      len_v = $urandom_range(0, DEPTH - 1);
      div_v = $urandom_range(0, 4);
      lp_v  = 1'($urandom_range(0, 1));
      s_v   = (lp_v || $urandom_range(0, 1) == 1) ? $urandom_range(1, 60) : 0;
      run_play("random", len_v, div_v, lp_v, s_v, 1'b0, 10'h000);
    end

    // reset mid-playback clears outputs and there is no resume
    bus_if.play_len = ADDR_W'(4);
    bus_if.rate_div = DIV_W'(0);
    bus_if.loop     = 1'b1;
    bus_if.start    = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    exp_out = {SMP_W{1'b0}};
    exp_or  = 1'b0;
    check_cycle("midreset", 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_cycle("noresume", 1'b0, 1'b0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/adc_sample_player.md
# adc_sample_player

Synthesizable, parametrised ADC sample source that replaces file-driven stimulus with an on-chip playback buffer. Up to four channels of samples are loaded through a write port, then replayed at a programmable rate, one-shot or looped, in `adc_clk` domain. Its output feeds the receive chain's `adc_data` input, so the radio can run on-target with known vectors and no external ADC.

## Interface
Parameters:
- `DATA_W`, 10: sample width per channel.
- `ADDR_W`, 10: buffer address width; depth = 2^ADDR_W.
- `CH_N`, 1: channel count, 1..4; one buffer bank per channel.
- `DIV_W`, 8: rate divider width.

Ports:
- `adc_clk`  in  1: sole clock.
- `rst`  in  1: synchronous, active-low reset.
- `wr_en`  in  1: buffer write strobe.
- `wr_ch`  in  2: target bank; values ≥ CH_N are ignored.
- `wr_addr`  in  ADDR_W: write address.
- `wr_data`  in  DATA_W: write data.
- `start`  in  1: begin playback; sampled in IDLE only.
- `stop`  in  1: abort playback.
- `loop`  in  1: loop mode, captured at accepted start.
- `play_len`  in  ADDR_W: samples per pass; 0 means 2^ADDR_W. Captured at start.
- `rate_div`  in  DIV_W: one sample per rate_div+1 clocks. Captured at start.
- `sample_out`  out  CH_N*DATA_W: channel k in bits [k*DATA_W +: DATA_W].
- `sample_valid`  out  1: one-cycle strobe per emitted sample.
- `busy`  out  1: high in PRIME/PLAY.
- `done`  out  1: one-cycle pulse at end of a one-shot pass.

## Operation
- Banks are simple dual-port RAM: one write port, one synchronous read port, 1-cycle read latency. A write to the address being read in the same cycle returns old data.
- FSM:
  - **IDLE**: `start` captures loop, len and div, sets rd_addr=0, and moves to PRIME.
  - **PRIME**: issues the read of address 0, then moves to PLAY.
  - **PLAY**: the divider counter counts 0..div. At terminal count it registers the read data to `sample_out`, pulses `sample_valid`, and advances rd_addr.
    - Last address (len-1) with `loop`=1: rd_addr wraps to 0 and playback continues with no gap.
    - Last address with `loop`=0: pulse `done` with the final `sample_valid` and return to IDLE.
- `stop` in PRIME/PLAY: go to IDLE next cycle. No further `sample_valid`, no `done`. `stop` has priority over a simultaneous terminal count.
- `start` outside IDLE is ignored. `start` and `stop` together in IDLE: `stop` wins and the FSM stays in IDLE.
- Writes are accepted in every state. Loaded content persists across playback and across reset (RAM is not cleared).
- `sample_out` holds its last value between strobes and after stop or done.
- Address arithmetic is modulo 2^ADDR_W. Internal len is ADDR_W+1 bits so that len=0 maps to full depth.

## Timing
- Reset, with `rst`=0 at an edge: `sample_out`=0, `sample_valid`=0, `busy`=0, `done`=0, FSM=IDLE, counters=0.
- `start` accepted at edge T0: `busy`=1 from T0+1. First `sample_valid` at T0+2+rate_div.
- Subsequent strobes every rate_div+1 cycles, including across a loop wrap.
- rate_div=0 gives one sample per clock, continuous.
- `done` is coincident with the last `sample_valid`. `busy` falls the cycle after.
- A new `start` is accepted the cycle after `busy` falls.
- Deasserting `rst` mid-playback takes effect at the next edge; there is no resume.

## Configuration
- `ADC_PLAYER_OVR_EN` defined: adds output `adc_or` (1 bit), registered alongside `sample_out` and valid with `sample_valid`. It is high when any channel's sample equals all-ones or all-zeros (full scale). Reset value is 0.
- Undefined: no `adc_or` port, no comparison logic.

## Test plan
- Reset: drive `rst`=0 for 4 cycles with random inputs → all outputs 0, `busy`=0.
- One-shot: load ramp 0..15 into bank 0, play_len=16, rate_div=0, loop=0 → 16 consecutive strobes carrying 0..15, `done` with sample 15, `busy` low one cycle later.
- Loop and divider: play_len=4, rate_div=3, loop=1, data {5,6,7,8} → strobes every 4 cycles: 5,6,7,8,5,6…, no `done`. `stop` issued → no strobe from the next cycle on.
- Full depth: ADDR_W=4, play_len=0 → 16 samples then `done`.
- Multichannel: CH_N=2, bank0=0x3FF and bank1=0x000 at address 0 → `sample_out`=0x003FF at the first strobe. With `ADC_PLAYER_OVR_EN` defined → `adc_or`=1.
- Conflicts:
  - `start`+`stop` together in IDLE → stays IDLE.
  - `start` during PLAY → ignored.
  - Write to the current read address → old value emitted on that read.
